// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage (with package alu_pkg)
// Description : Issue stage in front of the 8-bit enum-opcode ALU.
//               - Commands (a, b, op) arrive on a valid/ready handshake and
//                 are buffered in a DEPTH-entry FIFO.
//               - The FIFO head is shown to an external combinational ALU.
//               - The ALU result, its opcode and a sequence tag are captured
//                 in an output register with its own valid/ready handshake.
// Ports       : clk, rst_n                 clock, async active-low reset
//               in_valid/in_ready/in_a/in_b/in_op   command input
//               alu_a/alu_b/alu_op -> alu_y          external ALU hookup
//               res_valid/res_ready/res_y/res_op/res_tag  result output
//               count                                FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================

package alu_pkg;
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } opcode_e;
endpackage

module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  opcode_e                  in_op,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output opcode_e                  alu_op,
    input  logic [WIDTH-1:0]         alu_y,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_y,
    output opcode_e                  res_op,
    output logic [TAG_W-1:0]         res_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem_a  [DEPTH];
    logic [WIDTH-1:0]   r_mem_b  [DEPTH];
    opcode_e            r_mem_op [DEPTH];

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               r_res_valid;
    logic [WIDTH-1:0]   r_res_y;
    opcode_e            r_res_op;
    logic [TAG_W-1:0]   r_res_tag;
    logic [TAG_W-1:0]   r_next_tag;

    logic               w_full;
    logic               w_push;
    logic               w_issue;

    // Acceptance depends only on registered occupancy: a pop in the same
    // cycle never frees a slot for a push, keeping res_ready off this path.
    // rst_n gating forces in_ready low for the whole reset assertion.
    assign w_full   = (r_count == c_CNT_W'(DEPTH));
    assign in_ready = rst_n && !w_full;
    assign w_push   = in_valid && in_ready;

    // Issue whenever there is a command and the result register is free or
    // being emptied this cycle.
    assign w_issue  = (r_count != '0) && (!r_res_valid || res_ready);

    // Storage array carries no reset; only pointers/occupancy define state.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]  <= in_a;
            r_mem_b[r_wr_ptr]  <= in_b;
            r_mem_op[r_wr_ptr] <= in_op;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_y     <= '0;
            r_res_op    <= OP_ADD;
            r_res_tag   <= '0;
            r_next_tag  <= '0;
        end else if (w_issue) begin
            r_res_valid <= 1'b1;
            r_res_y     <= alu_y;
            r_res_op    <= r_mem_op[r_rd_ptr];
            r_res_tag   <= r_next_tag;
            r_next_tag  <= r_next_tag + TAG_W'(1);
        end else if (r_res_valid && res_ready) begin
            // Drain: payload is left in place, only valid drops.
            r_res_valid <= 1'b0;
        end
    end

    // Head of the FIFO; when empty this is a stale slot and is don't-care.
    assign alu_a     = r_mem_a[r_rd_ptr];
    assign alu_b     = r_mem_b[r_rd_ptr];
    assign alu_op    = r_mem_op[r_rd_ptr];

    assign res_valid = r_res_valid;
    assign res_y     = r_res_y;
    assign res_op    = r_res_op;
    assign res_tag   = r_res_tag;
    assign count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Directed self-checking bench for alu_issue_stage. Provides a
//               behavioural combinational ALU and checks reset, latency,
//               opcodes, backpressure, streaming with tag wrap, full-FIFO
//               pop-only behaviour and asynchronous reset mid-operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    opcode_e    in_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    opcode_e    alu_op;
    logic [7:0] alu_y;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_y;
    opcode_e    res_op;
    logic [3:0] res_tag;
    logic [2:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Behavioural ALU standing in for the real datapath.
    always_comb begin
        alu_y = 8'h00;
        case (alu_op)
            OP_ADD: alu_y = alu_a + alu_b;
            OP_SUB: alu_y = alu_a - alu_b;
            OP_AND: alu_y = alu_a & alu_b;
            OP_OR:  alu_y = alu_a | alu_b;
            default: alu_y = 8'h00;
        endcase
    end

    alu_issue_stage #(.WIDTH(8), .DEPTH(4), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_op    (res_op),
        .res_tag   (res_tag),
        .count     (count)
    );

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_op     = OP_ADD;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input opcode_e op);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        in_a = 8'h00; in_b = 8'h00; in_op = OP_ADD;
        #1;
        n_tests++;
        if ({in_ready, res_valid, count} !== {1'b0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready/res_valid/count got %b/%b/%0d want 0/0/0", in_ready, res_valid, count);
        end
        n_tests++;
        if ({res_y, res_op, res_tag} !== {8'h00, OP_ADD, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_data: y/op/tag got %h/%0d/%0d want 00/0/0", res_y, res_op, res_tag);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        res_ready = 1'b1;
        drive(8'h05, 8'h03, OP_ADD);
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if ({res_valid, count} !== {1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL single_latency: res_valid/count got %b/%0d want 0/1", res_valid, count);
        end
        @(negedge clk);
        n_tests++;
        if ({res_valid, res_y, res_op, res_tag} !== {1'b1, 8'h08, OP_ADD, 4'd0}) begin
            n_fail++;
            $display("FAIL single_result: v/y/op/tag got %b/%h/%0d/%0d want 1/08/0/0", res_valid, res_y, res_op, res_tag);
        end
        @(negedge clk);
        n_tests++;
        if ({res_valid, count} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL single_drain: res_valid/count got %b/%0d want 0/0", res_valid, count);
        end
    endtask

    task automatic test_ops();
        do_reset();
        res_ready = 1'b1;
        drive(8'h03, 8'h05, OP_SUB);
        @(negedge clk);
        drive(8'hF0, 8'h3C, OP_AND);
        @(negedge clk);
        n_tests++;
        if ({res_valid, res_y, res_op, res_tag} !== {1'b1, 8'hFE, OP_SUB, 4'd0}) begin
            n_fail++;
            $display("FAIL ops_sub: v/y/op/tag got %b/%h/%0d/%0d want 1/fe/1/0", res_valid, res_y, res_op, res_tag);
        end
        drive(8'hF0, 8'h0F, OP_OR);
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if ({res_valid, res_y, res_op, res_tag} !== {1'b1, 8'h30, OP_AND, 4'd1}) begin
            n_fail++;
            $display("FAIL ops_and: v/y/op/tag got %b/%h/%0d/%0d want 1/30/2/1", res_valid, res_y, res_op, res_tag);
        end
        @(negedge clk);
        n_tests++;
        if ({res_valid, res_y, res_op, res_tag} !== {1'b1, 8'hFF, OP_OR, 4'd2}) begin
            n_fail++;
            $display("FAIL ops_or: v/y/op/tag got %b/%h/%0d/%0d want 1/ff/3/2", res_valid, res_y, res_op, res_tag);
        end
        @(negedge clk);
        n_tests++;
        if ({res_valid, res_y, res_tag} !== {1'b0, 8'hFF, 4'd2}) begin
            n_fail++;
            $display("FAIL ops_hold_after_drain: v/y/tag got %b/%h/%0d want 0/ff/2", res_valid, res_y, res_tag);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(8'(8'h10 + i), 8'h20, OP_ADD);
            @(negedge clk);
        end
        // Sixth command offered while full: must not be taken.
        drive(8'hAA, 8'h01, OP_ADD);
        n_tests++;
        if ({in_ready, count, res_valid, res_y, res_tag} !== {1'b0, 3'd4, 1'b1, 8'h30, 4'd0}) begin
            n_fail++;
            $display("FAIL bp_full: rdy/cnt/v/y/tag got %b/%0d/%b/%h/%0d want 0/4/1/30/0", in_ready, count, res_valid, res_y, res_tag);
        end
        @(negedge clk);
        n_tests++;
        if ({count, res_valid, res_y, res_tag} !== {3'd4, 1'b1, 8'h30, 4'd0}) begin
            n_fail++;
            $display("FAIL bp_hold: cnt/v/y/tag got %0d/%b/%h/%0d want 4/1/30/0", count, res_valid, res_y, res_tag);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if ({res_valid, res_y, res_tag} !== {1'b1, 8'(8'h30 + k), 4'(k)}) begin
                n_fail++;
                $display("FAIL bp_release_%0d: v/y/tag got %b/%h/%0d want 1/%h/%0d", k, res_valid, res_y, res_tag, 8'(8'h30 + k), k);
            end
        end
        @(negedge clk);
        n_tests++;
        if ({res_valid, count} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL bp_empty: v/cnt got %b/%0d want 0/0", res_valid, count);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(8'(i), 8'h00, OP_OR);
            @(negedge clk);
        end
        // Full FIFO with pop and push request in the same cycle.
        res_ready = 1'b1;
        drive(8'h77, 8'h00, OP_OR);
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if ({count, in_ready, res_tag} !== {3'd3, 1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL full_pop_only: cnt/rdy/tag got %0d/%b/%0d want 3/1/1", count, in_ready, res_tag);
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if ({res_valid, count, res_tag, res_y} !== {1'b0, 3'd0, 4'd4, 8'h04}) begin
            n_fail++;
            $display("FAIL full_pop_drain: v/cnt/tag/y got %b/%0d/%0d/%h want 0/0/4/04", res_valid, count, res_tag, res_y);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        res_ready = 1'b1;
        for (int j = 0; j < 22; j++) begin
            if (j >= 2) begin
                n_tests++;
                if ({res_valid, res_y, res_tag} !== {1'b1, 8'((j - 2) * 3 + 1), 4'((j - 2) % 16)} || count > 3'd1) begin
                    n_fail++;
                    $display("FAIL stream_%0d: v/y/tag/cnt got %b/%h/%0d/%0d want 1/%h/%0d/<=1", j - 2, res_valid, res_y, res_tag, count, 8'((j - 2) * 3 + 1), (j - 2) % 16);
                end
            end
            if (j < 20) drive(8'(j * 3), 8'h01, OP_ADD);
            else        in_valid = 1'b0;
            @(negedge clk);
        end
        n_tests++;
        if ({res_valid, count, res_tag} !== {1'b0, 3'd0, 4'd3}) begin
            n_fail++;
            $display("FAIL stream_end: v/cnt/tag got %b/%0d/%0d want 0/0/3", res_valid, count, res_tag);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(8'(8'h40 + i), 8'h01, OP_SUB);
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_tests++;
        if ({count, res_valid} !== {3'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_pre: cnt/v got %0d/%b want 3/1", count, res_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({count, res_valid, in_ready, res_tag} !== {3'd0, 1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL midrst_async: cnt/v/rdy/tag got %0d/%b/%b/%0d want 0/0/0/0", count, res_valid, in_ready, res_tag);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        drive(8'h0F, 8'h30, OP_OR);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({res_valid, res_y, res_op, res_tag} !== {1'b1, 8'h3F, OP_OR, 4'd0}) begin
            n_fail++;
            $display("FAIL midrst_after: v/y/op/tag got %b/%h/%0d/%0d want 1/3f/3/0", res_valid, res_y, res_op, res_tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_ops();
        test_backpressure();
        test_full_pop();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
